// File: rtl/rr_arbiter_139.sv
// Four-way round-robin arbiter. Drives the winner as a {G_L, B, A} decoder select.
// It also provides decoded active-low grants. Every output is registered.
module rr_arbiter_139 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] REQ_L,
    output logic       G_L,
    output logic       B,
    output logic       A,
    output logic [3:0] GNT_L,
    output logic       BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nx;
    logic [1:0] ptr, ptr_nx;
    logic [1:0] sel, sel_nx;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] req;
    logic [1:0] winner;
    logic       any_req;
    logic       others_waiting;

    assign req = ~REQ_L;
    assign B   = sel[1];
    assign A   = sel[0];

    // First requester found when searching upward from the priority pointer, wrapping modulo 4.
    always_comb begin
        logic [1:0] idx;
        idx     = '0;
        winner  = ptr;
        any_req = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    assign others_waiting = |(req & ~(4'b0001 << sel));

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = GRANT;
                    sel_nx   = winner;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (cnt != CNT_LAST) begin
                    cnt_nx = cnt + 8'd1;
                end
                if (!req[sel] || (cnt == CNT_LAST && others_waiting)) begin
                    state_nx = IDLE;
                    ptr_nx   = sel + 2'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            G_L   <= 1'b1;
            GNT_L <= '1;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
            cnt   <= cnt_nx;
            G_L   <= (state_nx != GRANT);
            BUSY  <= (state_nx == GRANT);
            GNT_L <= (state_nx == GRANT) ? ~(4'b0001 << sel_nx) : '1;
        end
    end

endmodule
